// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } div_state_e;

  // Whole clk cycles the posedge duty flop stays high; odd N gets its extra half cycle from the negedge flop.
  function automatic int unsigned high_count(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and 50%-duty output formation for an active divisor n.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  output logic             boundary,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half;
  logic             pos_q;
  logic             neg_q;

  assign cnt_inc  = cnt + CNT_W'(1);
  assign half     = CNT_W'(high_count(32'(n)));
  assign boundary = !run || (cnt == n - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pos_q <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      pos_q <= 1'b1;
    end else if (!boundary) begin
      cnt   <= cnt_inc;
      pos_q <= (cnt_inc < half);
    end else begin
      cnt   <= '0;
      pos_q <= 1'b0;
    end
  end

  // Half-cycle extension of the high phase, only for odd divisors.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= pos_q & n[0];
  end

  assign clk_out = pos_q | neg_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty divider: load handshake, error pulse and enable/idle control.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DIV_RST = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick
);

  div_state_e       state;
  div_state_e       state_nxt;
  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] n_pend;
  logic             boundary;
  logic             start;
  logic             load_ok;
  logic             load_bad;

  assign start    = boundary && en;
  assign load_bad = div_load && (div_i < CNT_W'(DIV_MIN));
  assign load_ok  = div_load && !load_bad;

  always_comb begin
    state_nxt = state;
    if (start)         state_nxt = ST_RUN;
    else if (boundary) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A load in the same cycle as a start lands in pending and waits for the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_act    <= CNT_W'(DIV_RST);
      n_pend   <= CNT_W'(DIV_RST);
      div_busy <= 1'b0;
      div_err  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (start && div_busy) n_act <= n_pend;
      if (load_ok)           n_pend <= div_i;
      if (load_ok)           div_busy <= 1'b1;
      else if (start)        div_busy <= 1'b0;
      div_err <= load_bad;
      tick    <= start;
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == ST_RUN),
    .start   (start),
    .n       (n_act),
    .boundary(boundary),
    .clk_out (clk_out)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: time-based waveform model, checked every half clock cycle.
module tb_clk_div_prog;

  localparam int unsigned DIV_RST = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div_i = '0;
  logic       div_load = 1'b0;
  logic       div_busy;
  logic       div_err;
  logic       clk_out;
  logic       tick;
  logic [3:0] obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_div_prog #(
    .CNT_W  (8),
    .DIV_RST(DIV_RST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .div_i   (div_i),
    .div_load(div_load),
    .div_busy(div_busy),
    .div_err (div_err),
    .clk_out (clk_out),
    .tick    (tick)
  );

  assign obs = {clk_out, tick, div_busy, div_err};

  // Reference: a period starts at time m_t0 and lasts m_n*10; clk_out is high for its first m_n*5.
  logic       m_run = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] m_n = 8'(DIV_RST);
  logic [7:0] m_pend = 8'(DIV_RST);
  longint     m_t0 = 0;

  function automatic bit m_boundary();
    return !m_run || ((longint'($time) - m_t0) == longint'(m_n) * 10);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_busy <= 1'b0;
      m_err  <= 1'b0;
      m_n    <= 8'(DIV_RST);
      m_pend <= 8'(DIV_RST);
    end else begin
      m_err <= div_load && (div_i < 8'd2);
      if (m_boundary()) begin
        m_run <= en;
        if (en) begin
          m_t0 <= longint'($time);
          if (m_busy) m_n <= m_pend;
        end
      end
      if (div_load && (div_i >= 8'd2)) begin
        m_pend <= div_i;
        m_busy <= 1'b1;
      end else if (m_boundary() && en) begin
        m_busy <= 1'b0;
      end
    end
  end

  function automatic logic [3:0] expv();
    longint d;
    d = longint'($time) - m_t0;
    return {m_run && (d < longint'(m_n) * 5), m_run && (d < 10), m_busy, m_err};
  endfunction

  task automatic sync_to_tick(input string name);
    for (int w = 0; w < 40 && tick !== 1'b1; w++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("FAIL %s_sync t=%0t tick=%b required=1", name, $time, tick);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; div_load = 1'b0; div_i = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state t=%0t got=%b required=0000", $time, obs);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        checks++;
        if (clk_out !== 1'b1) begin
          failures++;
          $display("FAIL first_rise t=%0t clk_out=%b required=1", $time, clk_out);
        end
      end
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL reset_run t=%0t got=%b required=%b", $time, obs, expv());
      end
      @(negedge clk); #1;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL reset_run t=%0t got=%b required=%b", $time, obs, expv());
      end
    end
  endtask

  task automatic test_err();
    int n_err = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      div_load = (c == 2) || (c == 9);
      div_i = (c == 2) ? 8'd1 : 8'd0;
      #1;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL err_load t=%0t got=%b required=%b", $time, obs, expv());
      end
      @(posedge clk); #1;
      if (div_err === 1'b1) n_err++;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL err_load t=%0t got=%b required=%b", $time, obs, expv());
      end
    end
    checks++;
    if (n_err != 2) begin
      failures++;
      $display("FAIL err_pulse_count got=%0d required=2", n_err);
    end
  endtask

  task automatic test_loads();
    logic [7:0] vals [3];
    vals[0] = 8'd5; vals[1] = 8'd4; vals[2] = 8'd7;
    for (int v = 0; v < 3; v++) begin
      int unsigned at;
      at = $urandom_range(0, 6);
      for (int c = 0; c < 3 * int'(vals[v]) + 10; c++) begin
        @(negedge clk);
        div_load = (c == int'(at));
        div_i = vals[v];
        #1;
        checks++;
        if (obs !== expv()) begin
          failures++;
          $display("FAIL load_%0d t=%0t got=%b required=%b", vals[v], $time, obs, expv());
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== expv()) begin
          failures++;
          $display("FAIL load_%0d t=%0t got=%b required=%b", vals[v], $time, obs, expv());
        end
      end
    end
  endtask

  task automatic test_last_wins();
    sync_to_tick("last_wins");
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      div_load = (c == 0) || (c == 2);
      div_i = (c == 0) ? 8'd6 : 8'd9;
      #1;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL last_wins t=%0t got=%b required=%b", $time, obs, expv());
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL last_wins t=%0t got=%b required=%b", $time, obs, expv());
      end
    end
  endtask

  task automatic test_enable();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      div_load = (c == 0);
      div_i = 8'd5;
      @(posedge clk); #1;
    end
    sync_to_tick("enable");
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      div_load = 1'b0;
      if (c == 1)  en = 1'b0;
      if (c == 15) en = 1'b1;
      #1;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL enable t=%0t got=%b required=%b", $time, obs, expv());
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL enable t=%0t got=%b required=%b", $time, obs, expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      div_load = (c == 0);
      div_i = 8'd7;
      @(posedge clk); #1;
    end
    sync_to_tick("reset_mid");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_edge t=%0t got=%b required=0000", $time, obs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL reset_mid_run t=%0t got=%b required=%b", $time, obs, expv());
      end
      @(negedge clk); #1;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL reset_mid_run t=%0t got=%b required=%b", $time, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) en = ~en;
      div_load = ($urandom_range(0, 9) == 0);
      div_i = 8'($urandom_range(0, 14));
      #1;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL random t=%0t got=%b required=%b", $time, obs, expv());
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL random t=%0t got=%b required=%b", $time, obs, expv());
      end
    end
    @(negedge clk);
    div_load = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t bench did not complete", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_err();
    test_loads();
    test_last_wins();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider producing a 50%-duty output for any divisor N ≥ 2, odd or even. It is the generalised successor to the fixed divide-by-3/divide-by-5 dividers. Divisor changes are requested through a load handshake and take effect only at an output-period boundary, so no runt pulses occur. An enable gates the output cleanly. The block sits in the clocking area, driven by the 100 MHz system clock, and feeds downstream peripheral and test clocks.

## Interface
- `CNT_W`, default 8: divisor and counter width; legal N is 2 … 2^CNT_W−1.
- `DIV_RST`, default 3: divisor active after reset; must be ≥ 2.
- `clk`, in, 1: system clock; all logic on posedge except the single odd-duty negedge flop.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: run enable.
- `div_i`, in, CNT_W: requested divisor.
- `div_load`, in, 1: one-cycle pulse; samples `div_i`.
- `div_busy`, out, 1: a loaded divisor is pending and not yet applied.
- `div_err`, out, 1: one-cycle pulse when the loaded divisor is below 2.
- `clk_out`, out, 1: divided clock.
- `tick`, out, 1: one-cycle pulse (clk domain) coincident with each `clk_out` rising edge.

## Operation
- Active divisor N is held in a register and loaded from the pending register only at a period boundary.
- A period boundary is the posedge where the counter wraps from N−1 to 0. While idle, the first run posedge is also a boundary.
- Period is N `clk` cycles.
  - `clk_out` rises on a posedge `clk` at the start of the period.
  - It stays high for exactly N·T/2.
  - Even N: it falls on the posedge at count N/2.
  - Odd N: it falls on the negedge in the middle of count (N−1)/2.
  - Odd duty is formed as the OR of a posedge flop (high for counts 0 … (N−3)/2) and a negedge-retimed copy of it. Even N uses the posedge flop only.
- Loading:
  - `div_load` with `div_i` ≥ 2 writes the pending register and sets `div_busy`.
  - A new load while busy overwrites the pending value; the last load wins.
  - At the next boundary the pending value becomes N, and `div_busy` clears in the same cycle.
  - `div_load` with `div_i` < 2 pulses `div_err` for one cycle. Active and pending values are unchanged.
- Enable:
  - `en` is sampled at each boundary only.
  - If `en` drops mid-period, the current period completes (full high phase, full low phase). The block then idles with `clk_out` = 0.
  - While idle and `en` = 1, the next posedge starts a period.
  - A pending divisor applies on restart.
- `tick` is asserted in the cycle following each rising-edge posedge of `clk_out`.

## Timing
- Reset values:
  - `clk_out` = 0, `tick` = 0, `div_busy` = 0, `div_err` = 0.
  - Counter = 0, idle.
  - Active N = `DIV_RST`; pending = `DIV_RST`.
- All flops, including the negedge flop, clear asynchronously. Reset asserted mid-high-phase forces `clk_out` to 0 immediately.
- First `clk_out` rising edge is at the first posedge after `rst_n` release with `en` = 1.
- `div_err` is asserted in the cycle after the `div_load` posedge.
- `div_busy` is asserted in the cycle after `div_load`.
- Load latency:
  - A load accepted in the same cycle as a boundary misses that boundary and applies at the next one.
  - Worst-case latency to application is N_old + 1 cycles.
- Divisor changes never alter a period already in progress: the high time and period of the current cycle match N_old.
- The counter compares against N−1 using CNT_W-bit unsigned arithmetic; there is no wrap beyond N−1.

## Structure
- Package `clk_div_pkg`:
  - `DIV_MIN` = 2.
  - Helper function returning the high-phase count for N.
- Sub-module `clk_div_core`: counter, posedge/negedge duty flops and output OR, with active N as input and boundary as output.
- Top `clk_div_prog`: pending register, load handshake, error pulse, enable/idle control.

## Test plan
1. Reset with `DIV_RST` = 3, `en` = 1 (100 MHz). Required: every `clk_out` period = 30 ns, high = 15 ns; first rise at the first posedge after release.
2. Load N = 5, then N = 4, then N = 7 during running. Required:
   - Periods 50/40/70 ns with highs 25/20/35 ns.
   - Each change lands exactly at a boundary.
   - `div_busy` is high from the load until that boundary.
3. Two loads (6, then 9) within one period. Required: only 9 applies (period 90 ns, high 45 ns); no 60 ns period appears.
4. Load `div_i` = 1, then `div_i` = 0. Required: `div_err` pulses once per load, `div_busy` stays 0, and the period is unchanged at 30 ns.
5. With N = 5, drop `en` at count 1. Required: that period completes at 50 ns, then `clk_out` holds 0. Re-raising `en` starts a fresh 50 ns period at the next posedge.
6. Assert `rst_n` = 0 mid-high-phase with N = 7. Required: `clk_out` goes to 0 at the reset edge, and after release resumes with period 30 ns (`DIV_RST`).
